// File: rtl/ac97_pkg.sv
// rtl/ac97_pkg.sv - shared frame geometry and field positions for the AC97 serial-input receiver
package ac97_pkg;

  localparam int AC97_FRAME_BITS = 256;

  // Last bit position of each slot, counted from the sync rise
  localparam logic [7:0] TAG_END   = 8'd15;
  localparam logic [7:0] SLOT1_END = 8'd35;
  localparam logic [7:0] SLOT2_END = 8'd55;
  localparam logic [7:0] SLOT3_END = 8'd75;
  localparam logic [7:0] SLOT4_END = 8'd95;

  localparam int CODEC_READY_BIT = 15;
  localparam int ADDR_MSB        = 18;
  localparam int ADDR_LSB        = 12;
  localparam int REQ_MSB         = 11;
  localparam int REQ_LSB         = 2;

  // slot_valid holds tag bits 14..3, so slot n sits at index 12-n
  localparam int SV_SLOT1 = 11;
  localparam int SV_SLOT2 = 10;
  localparam int SV_SLOT3 = 9;
  localparam int SV_SLOT4 = 8;

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } align_state_e;

endpackage

// File: rtl/ac97_frame_align.sv
// rtl/ac97_frame_align.sv - sync edge detect, HUNT/RECV alignment, bit counter and lock tracking
// Optional good_frame output exists only with AC97_SLOT_RX_STATS_EN.
module ac97_frame_align
  import ac97_pkg::*;
#(
  parameter int LOCK_FRAMES = 2
) (
  input  logic       ac97_bitclk,
  input  logic       reset_b,
  input  logic       sync_q,
  output logic [7:0] bit_pos,
  output logic       bit_en,
  output logic       locked,
  output logic       frame_error
`ifdef AC97_SLOT_RX_STATS_EN
  ,
  output logic       good_frame
`endif
);

  localparam logic [3:0] LOCK_MAX = 4'(LOCK_FRAMES);

  align_state_e state, state_nx;
  logic [7:0]   cnt, cnt_nx;
  logic [3:0]   lock_cnt, lock_nx;
  logic         sync_prev, locked_nx, error_nx, rise;

  assign rise = sync_q & ~sync_prev;

  always_ff @(posedge ac97_bitclk or negedge reset_b) begin
    if (!reset_b) begin
      state       <= HUNT;
      cnt         <= 8'd0;
      lock_cnt    <= 4'd0;
      sync_prev   <= 1'b0;
      locked      <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      lock_cnt    <= lock_nx;
      sync_prev   <= sync_q;
      locked      <= locked_nx;
      frame_error <= error_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    lock_nx   = lock_cnt;
    locked_nx = locked;
    error_nx  = 1'b0;
    bit_pos   = cnt;
    bit_en    = 1'b0;
    case (state)
      HUNT: begin
        if (rise) begin
          state_nx = RECV;
          cnt_nx   = 8'd1;
          lock_nx  = 4'd1;
          bit_pos  = 8'd0;
          bit_en   = 1'b1;
        end
      end
      RECV: begin
        bit_en = 1'b1;
        cnt_nx = cnt + 8'd1;
        if (rise) begin
          if (cnt == 8'd0) begin
            if (lock_cnt < LOCK_MAX) lock_nx = lock_cnt + 4'd1;
            if (lock_nx >= LOCK_MAX) locked_nx = 1'b1;
          end else begin
            // Early sync: this cycle becomes bit 0 of a fresh frame
            error_nx  = 1'b1;
            cnt_nx    = 8'd1;
            lock_nx   = 4'd1;
            locked_nx = 1'b0;
            bit_pos   = 8'd0;
          end
        end else if (cnt == 8'd0) begin
          error_nx  = 1'b1;
          locked_nx = 1'b0;
          lock_nx   = 4'd0;
          cnt_nx    = 8'd0;
          bit_en    = 1'b0;
          state_nx  = HUNT;
        end
      end
      default: state_nx = HUNT;
    endcase
  end

`ifdef AC97_SLOT_RX_STATS_EN
  assign good_frame = (state == RECV) && rise && (cnt == 8'd0);
`endif

endmodule

// File: rtl/ac97_slot_rx.sv
// rtl/ac97_slot_rx.sv - AC97 sdata_in deserialiser: tag, status and PCM slot extraction
// AC97_SLOT_RX_STATS_EN adds frame_count and error_count outputs.
module ac97_slot_rx
  import ac97_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic                    ac97_bitclk,
  input  logic                    reset_b,
  input  logic                    ac97_sync,
  input  logic                    ac97_sdata_in,
  output logic                    locked,
  output logic                    codec_ready,
  output logic [11:0]             slot_valid,
  output logic                    status_valid,
  output logic [6:0]              status_addr,
  output logic [15:0]             status_data,
  output logic [9:0]              slot_req,
  output logic                    pcm_valid,
  output logic [SAMPLE_WIDTH-1:0] pcm_left,
  output logic [SAMPLE_WIDTH-1:0] pcm_right,
  output logic                    frame_error
`ifdef AC97_SLOT_RX_STATS_EN
  ,
  output logic [15:0]             frame_count,
  output logic [7:0]              error_count
`endif
);

  localparam int S1W = ADDR_MSB - REQ_LSB + 1;

  logic                    sync_q, sd_q, bit_en, status_ok, pcm_ok;
  logic [7:0]              bit_pos;
  logic [18:0]             shreg;
  logic [19:0]             word;
  logic [S1W-1:0]          slot1_q;
  logic [SAMPLE_WIDTH-1:0] slot3_q;
`ifdef AC97_SLOT_RX_STATS_EN
  logic                    good_frame;
`endif

  ac97_frame_align #(.LOCK_FRAMES(LOCK_FRAMES)) u_align (
    .ac97_bitclk (ac97_bitclk),
    .reset_b     (reset_b),
    .sync_q      (sync_q),
    .bit_pos     (bit_pos),
    .bit_en      (bit_en),
    .locked      (locked),
    .frame_error (frame_error)
`ifdef AC97_SLOT_RX_STATS_EN
    ,
    .good_frame  (good_frame)
`endif
  );

  // Current slot word including the bit arriving this cycle
  assign word      = {shreg, sd_q};
  assign status_ok = locked && codec_ready && slot_valid[SV_SLOT1] && slot_valid[SV_SLOT2];
  assign pcm_ok    = locked && codec_ready && (slot_valid[SV_SLOT3] || slot_valid[SV_SLOT4]);

  always_ff @(posedge ac97_bitclk or negedge reset_b) begin
    if (!reset_b) begin
      sync_q       <= 1'b0;
      sd_q         <= 1'b0;
      shreg        <= '0;
      slot1_q      <= '0;
      slot3_q      <= '0;
      codec_ready  <= 1'b0;
      slot_valid   <= '0;
      status_valid <= 1'b0;
      status_addr  <= '0;
      status_data  <= '0;
      slot_req     <= '0;
      pcm_valid    <= 1'b0;
      pcm_left     <= '0;
      pcm_right    <= '0;
    end else begin
      sync_q       <= ac97_sync;
      sd_q         <= ac97_sdata_in;
      shreg        <= word[18:0];
      status_valid <= 1'b0;
      pcm_valid    <= 1'b0;
      if (bit_en) begin
        case (bit_pos)
          TAG_END: begin
            codec_ready <= word[CODEC_READY_BIT];
            slot_valid  <= word[CODEC_READY_BIT-1:CODEC_READY_BIT-12];
          end
          SLOT1_END: slot1_q <= word[ADDR_MSB:REQ_LSB];
          SLOT2_END: begin
            if (status_ok) begin
              status_addr  <= slot1_q[ADDR_MSB-REQ_LSB:ADDR_LSB-REQ_LSB];
              slot_req     <= slot1_q[REQ_MSB-REQ_LSB:0];
              status_data  <= word[19:4];
              status_valid <= 1'b1;
            end
          end
          SLOT3_END: slot3_q <= word[19 -: SAMPLE_WIDTH];
          SLOT4_END: begin
            if (pcm_ok) begin
              if (slot_valid[SV_SLOT3]) pcm_left  <= slot3_q;
              if (slot_valid[SV_SLOT4]) pcm_right <= word[19 -: SAMPLE_WIDTH];
              pcm_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef AC97_SLOT_RX_STATS_EN
  always_ff @(posedge ac97_bitclk or negedge reset_b) begin
    if (!reset_b) begin
      frame_count <= 16'd0;
      error_count <= 8'd0;
    end else begin
      if (good_frame) frame_count <= frame_count + 16'd1;
      if (frame_error && (error_count != 8'hFF)) error_count <= error_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ac97_slot_rx.sv
// tb/tb_ac97_slot_rx.sv - self-checking bench for ac97_slot_rx (table-driven frames plus error/reset sequences)
module tb_ac97_slot_rx;

  logic        clk = 1'b0;
  logic        reset_b, sync, sdata;
  logic        locked, codec_ready, status_valid, pcm_valid, frame_error;
  logic [11:0] slot_valid;
  logic [6:0]  status_addr;
  logic [15:0] status_data, pcm_left, pcm_right;
  logic [9:0]  slot_req;
`ifdef AC97_SLOT_RX_STATS_EN
  logic [15:0] frame_count;
  logic [7:0]  error_count;
`endif

  int checks = 0, failures = 0;
  int cur_bit = 0;
  int tot_st = 0, tot_pc = 0, tot_er = 0, st_pos = -1, pc_pos = -1;

  always #5 clk = ~clk;

  ac97_slot_rx #(.SAMPLE_WIDTH(16), .LOCK_FRAMES(2)) dut (
    .ac97_bitclk   (clk),
    .reset_b       (reset_b),
    .ac97_sync     (sync),
    .ac97_sdata_in (sdata),
    .locked        (locked),
    .codec_ready   (codec_ready),
    .slot_valid    (slot_valid),
    .status_valid  (status_valid),
    .status_addr   (status_addr),
    .status_data   (status_data),
    .slot_req      (slot_req),
    .pcm_valid     (pcm_valid),
    .pcm_left      (pcm_left),
    .pcm_right     (pcm_right),
    .frame_error   (frame_error)
`ifdef AC97_SLOT_RX_STATS_EN
    ,
    .frame_count   (frame_count),
    .error_count   (error_count)
`endif
  );

  // Pulse monitor: records how many pulses occurred and at which driven bit index
  always @(posedge clk) begin
    #2;
    if (status_valid) begin tot_st++; st_pos = cur_bit; end
    if (pcm_valid)    begin tot_pc++; pc_pos = cur_bit; end
    if (frame_error)  tot_er++;
  end

  typedef struct {
    logic [15:0] tag;
    logic [19:0] s1, s2, s3, s4;
    logic        lk, cr;
    logic [11:0] sv;
    logic [6:0]  addr;
    logic [15:0] data;
    logic [9:0]  req;
    logic [15:0] pl, pr;
    int          nst, npc, ner;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic d, input int pos);
    @(negedge clk);
    sync    = s;
    sdata   = d;
    cur_bit = pos;
  endtask

  task automatic send_frame(input logic [15:0] tag, input logic [19:0] s1, input logic [19:0] s2,
                            input logic [19:0] s3, input logic [19:0] s4, input int len,
                            input logic with_sync);
    logic [255:0] fr;
    fr = '0;
    fr[255 -: 16] = tag;
    fr[239 -: 20] = s1;
    fr[219 -: 20] = s2;
    fr[199 -: 20] = s3;
    fr[179 -: 20] = s4;
    for (int i = 0; i < len; i++) drive(with_sync && (i < 16), fr[255-i], i);
  endtask

  // Sends one frame and checks pulse counts and lock state at its end
  task automatic frame_counts(input string name, input logic [15:0] tag, input int len,
                              input logic with_sync, input logic exp_lk,
                              input int exp_st, input int exp_pc, input int exp_er);
    int b_st, b_pc, b_er;
    b_st = tot_st; b_pc = tot_pc; b_er = tot_er;
    send_frame(tag, 20'h26000, 20'h000F0, 20'h12345, 20'hABCDE, len, with_sync);
    check({name, " locked"},      locked,        exp_lk);
    check({name, " status_cnt"},  tot_st - b_st, exp_st);
    check({name, " pcm_cnt"},     tot_pc - b_pc, exp_pc);
    check({name, " error_cnt"},   tot_er - b_er, exp_er);
  endtask

  function automatic logic [31:0] all_outputs_or();
    return 32'({locked, codec_ready, status_valid, pcm_valid, frame_error} != 0 ||
               slot_valid != 0 || status_addr != 0 || status_data != 0 || slot_req != 0 ||
               pcm_left != 0 || pcm_right != 0);
  endfunction

  initial begin
    int b_st, b_pc, b_er;
    vecs[0] = '{16'hF800, 20'h26000, 20'h000F0, 20'h12345, 20'hABCDE, 1'b0, 1'b1, 12'hF00, 7'h00, 16'h0000, 10'h000, 16'h0000, 16'h0000, 0, 0, 0};
    vecs[1] = '{16'hF800, 20'h26000, 20'h000F0, 20'h12345, 20'hABCDE, 1'b1, 1'b1, 12'hF00, 7'h26, 16'h000F, 10'h000, 16'h1234, 16'hABCD, 1, 1, 0};
    vecs[2] = '{16'hF800, 20'h26000, 20'h000F0, 20'h12345, 20'hABCDE, 1'b1, 1'b1, 12'hF00, 7'h26, 16'h000F, 10'h000, 16'h1234, 16'hABCD, 1, 1, 0};
    vecs[3] = '{16'hE000, 20'h12554, 20'hBEEF5, 20'h11111, 20'h22222, 1'b1, 1'b1, 12'hC00, 7'h12, 16'hBEEF, 10'h155, 16'h1234, 16'hABCD, 1, 0, 0};
    vecs[4] = '{16'h9800, 20'h00000, 20'h00000, 20'h5A5A5, 20'h0F0F0, 1'b1, 1'b1, 12'h300, 7'h12, 16'hBEEF, 10'h155, 16'h5A5A, 16'h0F0F, 0, 1, 0};
    vecs[5] = '{16'h9000, 20'h00000, 20'h00000, 20'hFFFFF, 20'h00001, 1'b1, 1'b1, 12'h200, 7'h12, 16'hBEEF, 10'h155, 16'hFFFF, 16'h0F0F, 0, 1, 0};
    vecs[6] = '{16'h0000, 20'h26000, 20'h000F0, 20'h12345, 20'hABCDE, 1'b1, 1'b0, 12'h000, 7'h12, 16'hBEEF, 10'h155, 16'hFFFF, 16'h0F0F, 0, 0, 0};
    vecs[7] = '{16'h7800, 20'h26000, 20'h000F0, 20'h77777, 20'h77777, 1'b1, 1'b0, 12'hF00, 7'h12, 16'hBEEF, 10'h155, 16'hFFFF, 16'h0F0F, 0, 0, 0};
    vecs[8] = '{16'h9800, 20'h00000, 20'h00000, 20'h8000F, 20'h7FFF0, 1'b1, 1'b1, 12'h300, 7'h12, 16'hBEEF, 10'h155, 16'h8000, 16'h7FFF, 0, 1, 0};

    reset_b = 1'b0;
    sync    = 1'b0;
    sdata   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset outputs", all_outputs_or(), 32'd0);
    reset_b = 1'b1;
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 0);
    check("idle locked", locked, 1'b0);

    for (int v = 0; v < 9; v++) begin
      b_st = tot_st; b_pc = tot_pc; b_er = tot_er;
      send_frame(vecs[v].tag, vecs[v].s1, vecs[v].s2, vecs[v].s3, vecs[v].s4, 256, 1'b1);
      check($sformatf("vec%0d locked", v),       locked,        vecs[v].lk);
      check($sformatf("vec%0d codec_ready", v),  codec_ready,   vecs[v].cr);
      check($sformatf("vec%0d slot_valid", v),   slot_valid,    vecs[v].sv);
      check($sformatf("vec%0d status_addr", v),  status_addr,   vecs[v].addr);
      check($sformatf("vec%0d status_data", v),  status_data,   vecs[v].data);
      check($sformatf("vec%0d slot_req", v),     slot_req,      vecs[v].req);
      check($sformatf("vec%0d pcm_left", v),     pcm_left,      vecs[v].pl);
      check($sformatf("vec%0d pcm_right", v),    pcm_right,     vecs[v].pr);
      check($sformatf("vec%0d status_cnt", v),   tot_st - b_st, vecs[v].nst);
      check($sformatf("vec%0d pcm_cnt", v),      tot_pc - b_pc, vecs[v].npc);
      check($sformatf("vec%0d error_cnt", v),    tot_er - b_er, vecs[v].ner);
      if (vecs[v].nst != 0) check($sformatf("vec%0d status_pos", v), st_pos, 56);
      if (vecs[v].npc != 0) check($sformatf("vec%0d pcm_pos", v),    pc_pos, 96);
    end

    // Early sync at count 100, then relock
    frame_counts("early_partial", 16'hF800, 100, 1'b1, 1'b1, 1, 1, 0);
    check("early_partial pcm_left", pcm_left, 16'h1234);
    frame_counts("early_realign", 16'hF800, 256, 1'b1, 1'b0, 0, 0, 1);
    frame_counts("early_relock",  16'hF800, 256, 1'b1, 1'b1, 1, 1, 0);

    // Missing sync drops to HUNT
    frame_counts("miss_nosync",   16'hF800, 256, 1'b0, 1'b0, 0, 0, 1);
    frame_counts("miss_hunt",     16'hF800, 256, 1'b1, 1'b0, 0, 0, 0);
    frame_counts("miss_relock",   16'hF800, 256, 1'b1, 1'b1, 1, 1, 0);

    // Asynchronous reset at bit 50
    b_st = tot_st; b_er = tot_er;
    send_frame(16'hF800, 20'h26000, 20'h000F0, 20'h12345, 20'hABCDE, 50, 1'b1);
    check("pre_reset locked", locked, 1'b1);
    #2;
    reset_b = 1'b0;
    #1;
    check("mid_reset outputs", all_outputs_or(), 32'd0);
    repeat (3) @(negedge clk);
    sync    = 1'b0;
    sdata   = 1'b0;
    reset_b = 1'b1;
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 0);
    check("post_reset status_cnt", tot_st - b_st, 0);
    check("post_reset error_cnt",  tot_er - b_er, 0);
    check("post_reset outputs", all_outputs_or(), 32'd0);
    frame_counts("rst_hunt",   16'hF800, 256, 1'b1, 1'b0, 0, 0, 0);
    frame_counts("rst_relock", 16'hF800, 256, 1'b1, 1'b1, 1, 1, 0);
    check("rst_relock status_addr", status_addr, 7'h26);
    check("rst_relock pcm_right",   pcm_right,   16'hABCD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ac97_slot_rx.md
Name: ac97_slot_rx

Overview:
- AC97 serial-input receiver. The existing AC97 controller already generates ac97_sync and ac97_sdata_out; this block is the opposite direction of that link.
- Deserialises the codec's ac97_sdata_in frames, aligned to ac97_sync. Extracts the tag slot, the status address/data (slots 1–2) and the PCM record samples (slots 3–4).
- Feeds codec-ready detection, register readback and future line-in capture, all in the ac97_bitclk domain.

Parameters:
- SAMPLE_WIDTH, 16: PCM output width (1..20); takes the MSBs of the 20-bit slot.
- LOCK_FRAMES, 2: number of consecutive correctly spaced syncs required before locked asserts (1..15).

Ports:
- ac97_bitclk    in   1   12.288 MHz bit clock; all logic on the rising edge.
- reset_b        in   1   asynchronous, active-low reset.
- ac97_sync      in   1   frame sync, as driven by the controller.
- ac97_sdata_in  in   1   codec serial data.
- locked         out  1   frame alignment established.
- codec_ready    out  1   tag bit 15 of the last complete tag slot.
- slot_valid     out  12  tag bits 14..3 (slots 1..12) of the last tag.
- status_valid   out  1   one-cycle pulse: new status_addr/status_data.
- status_addr    out  7   slot1 bits 18:12.
- status_data    out  16  slot2 bits 19:4.
- slot_req       out  10  slot1 bits 11:2 (codec slot requests).
- pcm_valid      out  1   one-cycle pulse: pcm_left and/or pcm_right updated.
- pcm_left       out  SAMPLE_WIDTH  slot3 MSBs.
- pcm_right      out  SAMPLE_WIDTH  slot4 MSBs.
- frame_error    out  1   one-cycle pulse on a misplaced or missing sync.

Behaviour:
- Reset: every output is 0; state = HUNT; bit counter = 0; lock count = 0.
- Inputs ac97_sync and ac97_sdata_in are registered once (sync_q, sd_q). All bit positions refer to the registered values.
- Bit 0 is the cycle in which sync_q is 1 and the previous sync_q was 0. Bit 0 carries tag bit 15.
- Frame layout by bit position:
  - tag: bits 0..15
  - slot1: bits 16..35
  - slot2: bits 36..55
  - slot3: bits 56..75
  - slot4: bits 76..95
  - bits 96..255 are ignored.
- Data arrives MSB first into a 20-bit shift register (16 bits for the tag).
- Bit counter is 8 bits. It increments each cycle in RECV and wraps 255→0.
- States:
  - HUNT: wait for a sync rise. On a rise, counter←1, lock count←1, state←RECV. No outputs update for this partial-alignment frame except through the RECV path below.
  - RECV: normal reception.
    - A sync rise exactly at wrap (counter == 0 expected) means a good frame. Increment lock count, saturating at LOCK_FRAMES. locked←1 when lock count reaches LOCK_FRAMES.
    - A sync rise at any other count: pulse frame_error, discard the partial frame, realign (counter←1), clear lock count to 1, locked←0.
    - No sync rise at the expected bit 0: pulse frame_error, locked←0, state←HUNT.
- Tag capture at bit 15: codec_ready and slot_valid update on the next cycle, regardless of locked.
- Status capture at bit 55: if locked, codec_ready, slot_valid[slot1] and slot_valid[slot2] are all 1, then:
  - status_addr, status_data and slot_req update;
  - status_valid pulses in the following cycle (latency 1 after the last slot2 bit).
  - Otherwise the values hold and no pulse is generated.
- PCM capture at bit 95: if locked and codec_ready are both 1:
  - pcm_left updates only if slot_valid for slot 3 is set; pcm_right updates only if slot 4 is set.
  - pcm_valid pulses if either updated.
  - A non-updated channel holds its value.
- Truncation: PCM = slot bits 19 : 20-SAMPLE_WIDTH. No rounding.
- Asynchronous reset mid-frame: immediate return to the reset values. No pulse may be emitted on the reset-release cycle.
- At most one of status_valid, pcm_valid and frame_error can pulse in any cycle, by construction of the capture positions.

Optional Feature:
- Macro AC97_SLOT_RX_STATS_EN.
- When defined, two extra outputs are present:
  - frame_count: 16 bits; counts good frames; wraps.
  - error_count: 8 bits; counts frame_error pulses; saturates at 255.
  - Both reset to 0.
- When undefined, these ports and counters do not exist, and all other behaviour is identical.

Decomposition:
- Package ac97_pkg holds:
  - AC97_FRAME_BITS = 256;
  - slot end positions TAG_END = 15, SLOT1_END = 35, SLOT2_END = 55, SLOT3_END = 75, SLOT4_END = 95;
  - the field index constants for codec_ready, the slot1 address and slot request fields.
- The natural sub-module is ac97_frame_align. It holds the sync edge detect, the HUNT/RECV state machine, the bit counter and lock counting, and outputs bit_pos, locked and frame_error.
- Slot extraction stays in ac97_slot_rx.

Test Plan:
- Lock: 3 frames with sync rising every 256 cycles and tag = 16'hF800 → locked=1 from the second good sync; codec_ready=1; slot_valid=12'hF00.
- Status read: slot1 addr = 7'h26, slot2 data = 16'h000F, tag = 16'hE000, locked → status_valid pulses once at bit 56; status_addr = 7'h26, status_data = 16'h000F.
- PCM: slot3 = 20'h12345, slot4 = 20'hABCDE, tag = 16'h9800 → pcm_valid at bit 96; pcm_left = 16'h1234, pcm_right = 16'hABCD. With tag = 16'h9000, only pcm_left changes.
- Early sync: sync rise at count 100 → frame_error pulse, locked=0, realigned; the next correct frame restores locked after LOCK_FRAMES.
- Missing sync: sync held low after a locked frame → one frame_error at expected bit 0, then state HUNT; no status_valid or pcm_valid pulses until relocked.
- Reset: assert reset_b low at bit 50 of a frame → all outputs 0 asynchronously; no status_valid pulse; the receiver re-hunts after release.
